mf_nco_clken: RTL and testbench

//  Parametrised digital clock-enable synthesiser: NUM_CH phase-accumulator (NCO) channels in one clock domain.

---
 rtl/mf_nco_clken.sv | 152 +++++++++++++++
 tb/tb_mf_nco_clken.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mf_nco_clken.sv
// Multi-channel phase-accumulator clock-enable synthesiser with runtime reprogramming
// and a settle/lock indication once the configuration has been stable long enough.
module mf_nco_clken #(
    parameter int unsigned NUM_CH      = 5,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_FREQ  = '0,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_PHASE = '0,
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_freq,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] clk_sq,
    output logic              locked
);

    localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SETTLE,
        S_LOCKED,
        S_APPLY
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ready_q;
    logic              locked_q;
    logic              err_q;
    logic [CH_W-1:0]   cap_ch_q;
    logic [ACC_W-1:0]  cap_freq_q;
    logic [ACC_W-1:0]  cap_phase_q;

    logic [ACC_W-1:0]  acc_q  [NUM_CH];
    logic [ACC_W-1:0]  acc_d  [NUM_CH];
    logic [ACC_W-1:0]  freq_q [NUM_CH];
    logic [ACC_W-1:0]  freq_d [NUM_CH];
    logic [ACC_W:0]    sum_w  [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] sq_q, sq_d;

    logic accept;
    logic ch_ok;

    assign accept = cfg_valid && ready_q;
    assign ch_ok  = (32'(cfg_ch) < NUM_CH);

    // The channel selected by a pending write is reloaded during APPLY instead of advancing.
    always_comb begin
        en_d = '0;
        sq_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum_w[i]  = {1'b0, acc_q[i]} + {1'b0, freq_q[i]};
            acc_d[i]  = sum_w[i][ACC_W-1:0];
            freq_d[i] = freq_q[i];
            en_d[i]   = sum_w[i][ACC_W];
            sq_d[i]   = sum_w[i][ACC_W-1];
            if ((state_q == S_APPLY) && (cap_ch_q == CH_W'(i))) begin
                acc_d[i]  = cap_phase_q;
                freq_d[i] = cap_freq_q;
                en_d[i]   = 1'b0;
                sq_d[i]   = cap_phase_q[ACC_W-1];
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= DEF_PHASE[i*ACC_W +: ACC_W];
                freq_q[i] <= DEF_FREQ[i*ACC_W +: ACC_W];
            end
            en_q <= '0;
            sq_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= acc_d[i];
                freq_q[i] <= freq_d[i];
            end
            en_q <= en_d;
            sq_q <= sq_d;
        end
    end

    // A valid write takes priority over the settle/lock progression on the same edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_SETTLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            cap_ch_q    <= '0;
            cap_freq_q  <= '0;
            cap_phase_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= S_LOCKED;
                        locked_q <= 1'b1;
                    end
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LOCKED: begin
                    locked_q <= 1'b1;
                end
                S_APPLY: begin
                    state_q  <= S_SETTLE;
                    cnt_q    <= '0;
                    ready_q  <= 1'b1;
                    locked_q <= 1'b0;
                end
                default: begin
                    state_q <= S_SETTLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                end
            endcase
            if (accept) begin
                if (ch_ok) begin
                    state_q     <= S_APPLY;
                    ready_q     <= 1'b0;
                    locked_q    <= 1'b0;
                    cap_ch_q    <= cfg_ch;
                    cap_freq_q  <= cfg_freq;
                    cap_phase_q <= cfg_phase;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign locked    = locked_q;
    assign clk_en    = en_q;
    assign clk_sq    = sq_q;

endmodule

// File: tb/tb_mf_nco_clken.sv
// Directed bench for mf_nco_clken: reset, free-running channels, reprogramming,
// out-of-range writes, settle restart and reset during a pending write.
module tb_mf_nco_clken;

    // Three channels so cfg_ch is 2 bits wide and channel 3 is out of range.
    localparam int unsigned NCH = 3;

    logic           refclk = 1'b0;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [7:0]     cfg_freq;
    logic [7:0]     cfg_phase;
    logic           cfg_err;
    logic [NCH-1:0] clk_en;
    logic [NCH-1:0] clk_sq;
    logic           locked;

    int checks = 0;
    int failures = 0;

    // Reference state for channels 0 and 1 (channel 2 stays idle throughout).
    logic [7:0] m0, f0, m1, f1, ph1, fr1;
    logic       apply1;
    logic [8:0] t9;
    logic [NCH-1:0] exp_en, exp_sq;

    mf_nco_clken #(
        .NUM_CH(NCH),
        .ACC_W(8),
        .LOCK_CYCLES(16),
        .DEF_FREQ({8'd0, 8'd0, 8'd64}),
        .DEF_PHASE(24'd0)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_freq(cfg_freq),
        .cfg_phase(cfg_phase),
        .cfg_err(cfg_err),
        .clk_en(clk_en),
        .clk_sq(clk_sq),
        .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic tick;
        @(posedge refclk);
        if (rst) begin
            m0 = 8'd0; f0 = 8'd64; m1 = 8'd0; f1 = 8'd0;
            apply1 = 1'b0;
            exp_en = '0; exp_sq = '0;
        end else begin
            t9 = {1'b0, m0} + {1'b0, f0};
            m0 = t9[7:0];
            exp_en[0] = t9[8];
            exp_sq[0] = t9[7];
            if (apply1) begin
                m1 = ph1; f1 = fr1;
                exp_en[1] = 1'b0;
                exp_sq[1] = ph1[7];
                apply1 = 1'b0;
            end else begin
                t9 = {1'b0, m1} + {1'b0, f1};
                m1 = t9[7:0];
                exp_en[1] = t9[8];
                exp_sq[1] = t9[7];
            end
            exp_en[2] = 1'b0;
            exp_sq[2] = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_freq = '0; cfg_phase = '0;
        repeat (3) tick();
        checks++; if (clk_en !== 3'b000) begin failures++; $display("FAIL reset_clk_en got=%b exp=000", clk_en); end
        checks++; if (clk_sq !== 3'b000) begin failures++; $display("FAIL reset_clk_sq got=%b exp=000", clk_sq); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    endtask

    task automatic test_release_and_lock;
        logic [3:0] sq_pat;
        sq_pat = 4'b0110;
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (clk_sq !== {2'b00, sq_pat[3 - ((k - 1) % 4)]}) begin
                failures++; $display("FAIL release_clk_sq k=%0d got=%b exp=%b", k, clk_sq, {2'b00, sq_pat[3 - ((k - 1) % 4)]});
            end
            checks++;
            if (clk_en !== {2'b00, (k % 4 == 0)}) begin
                failures++; $display("FAIL release_clk_en k=%0d got=%b exp=%b", k, clk_en, {2'b00, (k % 4 == 0)});
            end
            checks++;
            if (locked !== (k >= 16)) begin
                failures++; $display("FAIL release_locked k=%0d got=%b exp=%b", k, locked, (k >= 16));
            end
        end
    endtask

    task automatic test_write_locked;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_freq = 8'd128; cfg_phase = 8'd128;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL wr_ready_before got=%b exp=1", cfg_ready); end
        tick();
        cfg_valid = 1'b0;
        ph1 = 8'd128; fr1 = 8'd128; apply1 = 1'b1;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL apply_ready got=%b exp=0", cfg_ready); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL apply_locked got=%b exp=0", locked); end
        checks++; if (clk_en !== exp_en) begin failures++; $display("FAIL apply_clk_en got=%b exp=%b", clk_en, exp_en); end
        tick();
        checks++; if (clk_sq !== {1'b0, 1'b1, exp_sq[0]}) begin failures++; $display("FAIL applied_clk_sq got=%b exp=%b", clk_sq, {1'b0, 1'b1, exp_sq[0]}); end
        checks++; if (clk_en[1] !== 1'b0) begin failures++; $display("FAIL applied_clk_en1 got=%b exp=0", clk_en[1]); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL applied_ready got=%b exp=1", cfg_ready); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (clk_en[1] !== (k % 2 == 1)) begin failures++; $display("FAIL ch1_en k=%0d got=%b exp=%b", k, clk_en[1], (k % 2 == 1)); end
            checks++;
            if ({clk_en, clk_sq} !== {exp_en, exp_sq}) begin
                failures++; $display("FAIL wr_channels k=%0d got=%b/%b exp=%b/%b", k, clk_en, clk_sq, exp_en, exp_sq);
            end
            checks++;
            if (locked !== (k == 16)) begin failures++; $display("FAIL relock k=%0d got=%b exp=%b", k, locked, (k == 16)); end
        end
    endtask

    task automatic test_bad_channel;
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_freq = 8'd5; cfg_phase = 8'd7;
        tick();
        cfg_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL err_ready got=%b exp=1", cfg_ready); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL err_locked got=%b exp=1", locked); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL err_single k=%0d got=%b exp=0", k, cfg_err); end
            checks++; if (locked !== 1'b1) begin failures++; $display("FAIL err_locked_after k=%0d got=%b exp=1", k, locked); end
            checks++;
            if ({clk_en, clk_sq} !== {exp_en, exp_sq}) begin
                failures++; $display("FAIL err_channels k=%0d got=%b/%b exp=%b/%b", k, clk_en, clk_sq, exp_en, exp_sq);
            end
        end
    endtask

    task automatic test_settle_restart;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_freq = 8'd64; cfg_phase = 8'd0;
        tick();
        cfg_valid = 1'b0;
        ph1 = 8'd0; fr1 = 8'd64; apply1 = 1'b1;
        tick();
        repeat (10) tick();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_freq = 8'd32; cfg_phase = 8'd64;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL restart_ready got=%b exp=1", cfg_ready); end
        tick();
        cfg_valid = 1'b0;
        ph1 = 8'd64; fr1 = 8'd32; apply1 = 1'b1;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL restart_apply_ready got=%b exp=0", cfg_ready); end
        tick();
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (locked !== (k == 16)) begin failures++; $display("FAIL restart_locked k=%0d got=%b exp=%b", k, locked, (k == 16)); end
            checks++;
            if ({clk_en, clk_sq} !== {exp_en, exp_sq}) begin
                failures++; $display("FAIL restart_channels k=%0d got=%b/%b exp=%b/%b", k, clk_en, clk_sq, exp_en, exp_sq);
            end
        end
    endtask

    task automatic test_reset_mid_apply;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_freq = 8'd200; cfg_phase = 8'd200;
        tick();
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL midrst_apply_ready got=%b exp=0", cfg_ready); end
        rst = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready k=%0d got=%b exp=1", k, cfg_ready); end
            checks++; if (locked !== 1'b0) begin failures++; $display("FAIL midrst_locked k=%0d got=%b exp=0", k, locked); end
            checks++;
            if ({clk_en, clk_sq} !== 6'b000000) begin
                failures++; $display("FAIL midrst_outputs k=%0d got=%b/%b exp=000/000", k, clk_en, clk_sq);
            end
        end
        cfg_valid = 1'b0;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if ({clk_en, clk_sq} !== {exp_en, exp_sq}) begin
                failures++; $display("FAIL postrst_channels k=%0d got=%b/%b exp=%b/%b", k, clk_en, clk_sq, exp_en, exp_sq);
            end
            checks++; if (locked !== 1'b0) begin failures++; $display("FAIL postrst_locked k=%0d got=%b exp=0", k, locked); end
        end
    endtask

    initial begin
        apply1 = 1'b0;
        m0 = '0; f0 = '0; m1 = '0; f1 = '0; ph1 = '0; fr1 = '0;
        exp_en = '0; exp_sq = '0;
        test_reset();
        test_release_and_lock();
        test_write_locked();
        test_bad_channel();
        test_settle_restart();
        test_reset_mid_apply();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
